// File: rtl/data_mem_ctrl.sv
// Byte-addressable little-endian data memory with a 1-cycle registered response and a post-reset clear sweep.
// Optional per-byte even parity is built when DMEM_PARITY_EN is defined.
module data_mem_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int DEPTH_BYTES    = 64,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_signed,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
`ifdef DMEM_PARITY_EN
    input  logic              i_perr_inject,
    output logic              o_rsp_perr,
`endif
    output logic              o_busy
);
    localparam int NB    = DATA_W / 8;
    localparam int WORDS = DEPTH_BYTES / NB;
    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int PTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    logic [7:0]        r_mem [DEPTH_BYTES];
    state_t            r_state;
    logic [PTR_W-1:0]  r_clr_ptr;
    logic              r_ready;
    logic              r_busy;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic              w_accept;
    logic              w_wr;
    logic              w_clr_wr;
    int unsigned       w_nbytes;
    logic              w_size_err;
    logic              w_mis_err;
    logic              w_range_err;
    logic              w_err;
    logic [ADDR_W:0]   w_end;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_clr_base;
    logic [DATA_W-1:0] w_load;
    logic              w_sign;
    logic              w_perr_rd;

`ifdef DMEM_PARITY_EN
    logic              r_par [DEPTH_BYTES];
    logic              r_rsp_perr;
    logic              w_inject;
    assign w_inject   = i_perr_inject;
    assign o_rsp_perr = r_rsp_perr;
`endif

    assign w_accept   = i_req_valid & r_ready;
    assign w_idx      = i_req_addr[IDX_W-1:0];
    assign w_clr_base = IDX_W'(r_clr_ptr) * IDX_W'(NB);
    assign w_clr_wr   = !i_reset && (r_state == S_CLEAR) && (CLEAR_ON_RESET != 0);

    always_comb begin
        w_nbytes   = 1;
        w_size_err = 1'b0;
        w_mis_err  = 1'b0;
        case (i_req_size)
            2'd0: w_nbytes = 1;
            2'd1: begin
                w_nbytes  = 2;
                w_mis_err = i_req_addr[0];
            end
            2'd2: begin
                w_nbytes   = 4;
                w_mis_err  = |i_req_addr[1:0];
                w_size_err = (DATA_W < 32);
            end
            default: begin
                w_nbytes   = 1;
                w_size_err = 1'b1;
            end
        endcase
    end

    // Range check is done one bit wider so addresses near the top of ADDR_W cannot wrap.
    assign w_end       = {1'b0, i_req_addr} + (ADDR_W+1)'(w_nbytes);
    assign w_range_err = w_end > (ADDR_W+1)'(DEPTH_BYTES);
    assign w_err       = w_size_err | w_mis_err | w_range_err;
    assign w_wr        = w_accept & i_req_we & ~w_err;

    always_comb begin
        w_load    = '0;
        w_sign    = 1'b0;
        w_perr_rd = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (k < int'(w_nbytes)) begin
                w_load[8*k +: 8] = r_mem[w_idx + IDX_W'(k)];
`ifdef DMEM_PARITY_EN
                if (r_par[w_idx + IDX_W'(k)] != ^r_mem[w_idx + IDX_W'(k)])
                    w_perr_rd = 1'b1;
`endif
            end
            if (k == int'(w_nbytes) - 1)
                w_sign = r_mem[w_idx + IDX_W'(k)][7];
        end
        for (int k = 0; k < NB; k++)
            if (k >= int'(w_nbytes))
                w_load[8*k +: 8] = {8{w_sign & i_req_signed}};
    end

    always_ff @(posedge i_clk) begin
        if (w_clr_wr) begin
            for (int k = 0; k < NB; k++) begin
                r_mem[w_clr_base + IDX_W'(k)] <= 8'h00;
`ifdef DMEM_PARITY_EN
                r_par[w_clr_base + IDX_W'(k)] <= 1'b0;
`endif
            end
        end else if (w_wr) begin
            for (int k = 0; k < NB; k++) begin
                if (k < int'(w_nbytes)) begin
                    r_mem[w_idx + IDX_W'(k)] <= i_req_wdata[8*k +: 8];
`ifdef DMEM_PARITY_EN
                    r_par[w_idx + IDX_W'(k)] <= ^i_req_wdata[8*k +: 8] ^ w_inject;
`endif
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_CLEAR;
            r_clr_ptr   <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef DMEM_PARITY_EN
            r_rsp_perr  <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || i_req_we) ? '0 : w_load;
`ifdef DMEM_PARITY_EN
                r_rsp_perr  <= !w_err && !i_req_we && w_perr_rd;
`endif
            end
            case (r_state)
                S_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (CLEAR_ON_RESET == 0 || r_clr_ptr == PTR_W'(WORDS - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready = r_ready;
    assign o_busy      = r_busy;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

    logic w_unused;
    assign w_unused = w_perr_rd;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl at defaults (DATA_W=16, DEPTH_BYTES=64).
// Define DMEM_PARITY_EN for both files to include the parity case.
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        perr_inject = 1'b0;
    logic        rsp_perr;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    data_mem_ctrl dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_size   (req_size),
        .i_req_signed (req_signed),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
`ifdef DMEM_PARITY_EN
        .i_perr_inject(perr_inject),
        .o_rsp_perr   (rsp_perr),
`endif
        .o_busy       (busy)
    );

`ifndef DMEM_PARITY_EN
    assign rsp_perr = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic req(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [15:0] a, input logic [15:0] wd, input logic inj,
                       output logic [15:0] rd, output logic er, output logic pe);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; perr_inject = inj;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".vld"}, 32'(rsp_valid), 32'd1);
        rd = rsp_rdata; er = rsp_err; pe = rsp_perr;
        req_valid = 1'b0; perr_inject = 1'b0;
    endtask

    task automatic ld(input string tag, input logic [1:0] sz, input logic sg, input logic [15:0] a,
                      input logic [15:0] exp_d, input logic exp_e);
        logic [15:0] rd; logic er, pe;
        req(tag, 1'b0, sz, sg, a, 16'h0, 1'b0, rd, er, pe);
        chk({tag, ".data"}, 32'(rd), 32'(exp_d));
        chk({tag, ".err"}, 32'(er), 32'(exp_e));
    endtask

    task automatic st(input string tag, input logic [1:0] sz, input logic [15:0] a,
                      input logic [15:0] wd, input logic exp_e);
        logic [15:0] rd; logic er, pe;
        req(tag, 1'b1, sz, 1'b0, a, wd, 1'b0, rd, er, pe);
        chk({tag, ".data"}, 32'(rd), 32'h0);
        chk({tag, ".err"}, 32'(er), 32'(exp_e));
    endtask

    // Counts busy negedges starting at the release negedge; also counts stray responses.
    task automatic wait_clear(output int cnt, output int nrsp);
        cnt = 0; nrsp = 0;
        while (busy && cnt < 200) begin
            if (rsp_valid) nrsp++;
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt, nrsp, pre;
        @(negedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rdata", 32'(rsp_rdata), 32'd0);
        chk("rst.err", 32'(rsp_err), 32'd0);
        chk("rst.busy", 32'(busy), 32'd1);
        reset = 1'b0;
        wait_clear(cnt, nrsp);
        chk("init.busy_cycles", 32'(cnt), 32'd32);
        chk("init.ready", 32'(req_ready), 32'd1);

        // Preload, then reset for 2 cycles and confirm the sweep zeroed it
        st("pre.st3e", 2'd1, 16'h3E, 16'h1234, 1'b0);
        st("pre.st00", 2'd1, 16'h00, 16'hCAFE, 1'b0);
        ld("pre.ld3e", 2'd1, 1'b0, 16'h3E, 16'h1234, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_clear(cnt, nrsp);
        chk("t1.busy_cycles", 32'(cnt), 32'd32);
        chk("t1.ready", 32'(req_ready), 32'd1);
        ld("t1.ld3e", 2'd1, 1'b0, 16'h3E, 16'h0000, 1'b0);
        ld("t1.ld00", 2'd1, 1'b0, 16'h00, 16'h0000, 1'b0);

        st("t2.st", 2'd1, 16'h10, 16'hA55A, 1'b0);
        ld("t2.b10", 2'd0, 1'b0, 16'h10, 16'h005A, 1'b0);
        ld("t2.b11u", 2'd0, 1'b0, 16'h11, 16'h00A5, 1'b0);
        ld("t2.b11s", 2'd0, 1'b1, 16'h11, 16'hFFA5, 1'b0);
        ld("t2.h10s", 2'd1, 1'b1, 16'h10, 16'hA55A, 1'b0);
        ld("t2.b10s", 2'd0, 1'b1, 16'h10, 16'h005A, 1'b0);

        st("t3.st", 2'd0, 16'h21, 16'h007F, 1'b0);
        ld("t3.h20", 2'd1, 1'b0, 16'h20, 16'h7F00, 1'b0);
        ld("t3.b20", 2'd0, 1'b0, 16'h20, 16'h0000, 1'b0);

        st("t4.st12", 2'd1, 16'h12, 16'h1122, 1'b0);
        st("t4.mis", 2'd1, 16'h13, 16'hBEEF, 1'b1);
        ld("t4.b12", 2'd0, 1'b0, 16'h12, 16'h0022, 1'b0);
        ld("t4.b13", 2'd0, 1'b0, 16'h13, 16'h0011, 1'b0);
        ld("t4.h12", 2'd1, 1'b0, 16'h12, 16'h1122, 1'b0);
        ld("t4.h3f", 2'd1, 1'b0, 16'h3F, 16'h0000, 1'b1);
        ld("t4.b3f", 2'd0, 1'b0, 16'h3F, 16'h0000, 1'b0);
        ld("t4.h3e", 2'd1, 1'b0, 16'h3E, 16'h0000, 1'b0);
        ld("t4.b40", 2'd0, 1'b0, 16'h40, 16'h0000, 1'b1);
        ld("t4.w00", 2'd2, 1'b0, 16'h00, 16'h0000, 1'b1);
        st("t4.stb40", 2'd0, 16'h40, 16'h00AA, 1'b1);
        ld("t4.h10", 2'd1, 1'b0, 16'h10, 16'hA55A, 1'b0);
        ld("t4.sz3", 2'd3, 1'b0, 16'h00, 16'h0000, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("hold.vld", 32'(rsp_valid), 32'd0);
        chk("hold.err", 32'(rsp_err), 32'd1);

        // Reset pulse in the middle of a sweep while requests are held on the port
        reset = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_addr = 16'h10;
        @(negedge clk);
        reset = 1'b0;
        pre = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) pre++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_clear(cnt, nrsp);
        req_valid = 1'b0;
        chk("t5.busy_cycles", 32'(cnt), 32'd32);
        chk("t5.rsp_during_busy", 32'(nrsp + pre), 32'd0);
        @(negedge clk);
        chk("t5.no_rsp_after", 32'(rsp_valid), 32'd0);
        ld("t5.h10", 2'd1, 1'b0, 16'h10, 16'h0000, 1'b0);

`ifdef DMEM_PARITY_EN
        begin
            logic [15:0] rd; logic er, pe;
            req("t6.st_inj", 1'b1, 2'd1, 1'b0, 16'h08, 16'h1234, 1'b1, rd, er, pe);
            req("t6.ld_bad", 1'b0, 2'd1, 1'b0, 16'h08, 16'h0, 1'b0, rd, er, pe);
            chk("t6.bad.data", 32'(rd), 32'h1234);
            chk("t6.bad.perr", 32'(pe), 32'd1);
            chk("t6.bad.err", 32'(er), 32'd0);
            req("t6.ld_mis", 1'b0, 2'd1, 1'b0, 16'h09, 16'h0, 1'b0, rd, er, pe);
            chk("t6.mis.perr", 32'(pe), 32'd0);
            chk("t6.mis.err", 32'(er), 32'd1);
            req("t6.st_ok", 1'b1, 2'd1, 1'b0, 16'h08, 16'h1234, 1'b0, rd, er, pe);
            req("t6.ld_ok", 1'b0, 2'd1, 1'b0, 16'h08, 16'h0, 1'b0, rd, er, pe);
            chk("t6.ok.data", 32'(rd), 32'h1234);
            chk("t6.ok.perr", 32'(pe), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
